// File: rtl/avalon_burst_master_if.sv
// avalon_burst_master_if: command, write/read beat streams and Avalon-MM master side of the burst master
interface avalon_burst_master_if #(
   parameter int ADDR_WIDTH  = 30,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 8
);
   logic                   i_Cmd_Valid;
   logic                   o_Cmd_Ready;
   logic                   i_Cmd_Write;
   logic [ADDR_WIDTH-1:0]  i_Cmd_Addr;
   logic [3:0]             i_Cmd_ByteEn;
   logic [BURST_WIDTH-1:0] i_Cmd_BurstCount;
   logic [DATA_WIDTH-1:0]  i_WrData;
   logic                   i_WrData_Valid;
   logic                   o_WrData_Ready;
   logic [DATA_WIDTH-1:0]  o_RdData;
   logic                   o_RdData_Valid;
   logic                   o_Done;
   logic [ADDR_WIDTH-1:0]  o_AV_Addr;
   logic [3:0]             o_AV_ByteEn;
   logic                   o_AV_Read;
   logic                   o_AV_Write;
   logic [DATA_WIDTH-1:0]  o_AV_WriteData;
   logic [BURST_WIDTH-1:0] o_AV_BurstCount;
   logic [DATA_WIDTH-1:0]  i_AV_ReadData;
   logic                   i_AV_WaitRequest;

   modport master (
      input  i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_ByteEn, i_Cmd_BurstCount,
      input  i_WrData, i_WrData_Valid, i_AV_ReadData, i_AV_WaitRequest,
      output o_Cmd_Ready, o_WrData_Ready, o_RdData, o_RdData_Valid, o_Done,
      output o_AV_Addr, o_AV_ByteEn, o_AV_Read, o_AV_Write, o_AV_WriteData, o_AV_BurstCount
   );

   modport slave (
      output i_Cmd_Valid, i_Cmd_Write, i_Cmd_Addr, i_Cmd_ByteEn, i_Cmd_BurstCount,
      output i_WrData, i_WrData_Valid, i_AV_ReadData, i_AV_WaitRequest,
      input  o_Cmd_Ready, o_WrData_Ready, o_RdData, o_RdData_Valid, o_Done,
      input  o_AV_Addr, o_AV_ByteEn, o_AV_Read, o_AV_Write, o_AV_WriteData, o_AV_BurstCount
   );
endinterface

// File: rtl/avalon_burst_master.sv
// avalon_burst_master: turns burst read/write commands into Avalon-MM burst transactions
module avalon_burst_master #(
   parameter int ADDR_WIDTH  = 30,
   parameter int DATA_WIDTH  = 32,
   parameter int BURST_WIDTH = 8
) (
   input logic                   i_Clk,
   input logic                   i_Reset,
   avalon_burst_master_if.master bus
);
   typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

   state_t                 state, stateNext;
   logic [ADDR_WIDTH-1:0]  addrReg;
   logic [3:0]             byteEnReg;
   logic [BURST_WIDTH-1:0] burstReg, beatsLeft, fetched;
   logic [DATA_WIDTH-1:0]  holdData, rdData;
   logic                   holdValid, rdValid, done;
   logic                   cmdFire, zeroCmd, beat, lastBeat, wrReady, wrFire;

   always_ff @(posedge i_Clk)
      if (i_Reset) state <= IDLE;
      else state <= stateNext;

   always_comb begin
      cmdFire   = bus.i_Cmd_Valid && state == IDLE;
      zeroCmd   = cmdFire && bus.i_Cmd_BurstCount == '0;
      beat      = (state == READ || (state == WRITE && holdValid)) && !bus.i_AV_WaitRequest;
      lastBeat  = beat && beatsLeft == BURST_WIDTH'(1);
      wrReady   = state == WRITE && fetched < burstReg && (!holdValid || beat);
      wrFire    = wrReady && bus.i_WrData_Valid;
      stateNext = lastBeat ? IDLE
                : (cmdFire && !zeroCmd) ? (bus.i_Cmd_Write ? WRITE : READ)
                : state;
   end

   // holdValid doubles as the Avalon write strobe, so a beat leaves it only once it completes
   always_ff @(posedge i_Clk)
      if (i_Reset) begin
         addrReg   <= '0;
         byteEnReg <= '0;
         burstReg  <= '0;
         beatsLeft <= '0;
         fetched   <= '0;
         holdData  <= '0;
         holdValid <= 1'b0;
         rdData    <= '0;
         rdValid   <= 1'b0;
         done      <= 1'b0;
      end else begin
         done    <= zeroCmd || lastBeat;
         rdValid <= state == READ && beat;
         if (state == READ && beat) rdData <= bus.i_AV_ReadData;
         if (cmdFire) begin
            addrReg   <= bus.i_Cmd_Addr;
            byteEnReg <= bus.i_Cmd_ByteEn;
            burstReg  <= bus.i_Cmd_BurstCount;
            beatsLeft <= bus.i_Cmd_BurstCount;
            fetched   <= '0;
         end else if (beat) beatsLeft <= beatsLeft - BURST_WIDTH'(1);
         if (wrFire) begin
            holdData  <= bus.i_WrData;
            holdValid <= 1'b1;
            fetched   <= fetched + BURST_WIDTH'(1);
         end else if (beat) holdValid <= 1'b0;
      end

   assign bus.o_Cmd_Ready     = state == IDLE;
   assign bus.o_WrData_Ready  = wrReady;
   assign bus.o_AV_Addr       = state == IDLE ? '0 : addrReg;
   assign bus.o_AV_ByteEn     = state == IDLE ? '0 : byteEnReg;
   assign bus.o_AV_BurstCount = state == IDLE ? '0 : burstReg;
   assign bus.o_AV_Read       = state == READ;
   assign bus.o_AV_Write      = state == WRITE && holdValid;
   assign bus.o_AV_WriteData  = holdValid ? holdData : '0;
   assign bus.o_RdData        = rdData;
   assign bus.o_RdData_Valid  = rdValid;
   assign bus.o_Done          = done;
endmodule

// File: tb/tb_avalon_burst_master.sv
// tb_avalon_burst_master: directed bursts against a transaction-level model of the burst master
module tb_avalon_burst_master;
   logic r_Clk = 1'b0;
   logic r_Reset = 1'b1;
   always #5 r_Clk = ~r_Clk;

   avalon_burst_master_if #(.ADDR_WIDTH(30), .DATA_WIDTH(32), .BURST_WIDTH(8)) bus ();

   avalon_burst_master #(.ADDR_WIDTH(30), .DATA_WIDTH(32), .BURST_WIDTH(8)) dut (
      .i_Clk(r_Clk),
      .i_Reset(r_Reset),
      .bus(bus)
   );

   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // responder: waitLeft wait cycles before the next beat, reloaded with perBeatWait after each beat
   int waitLeft = 0;
   int perBeatWait = 0;
   int rdIdx = 0;
   logic [31:0] rdBase = '0;
   always @(posedge r_Clk) begin
      #2;
      if (bus.o_AV_Read || bus.o_AV_Write) begin
         if (waitLeft > 0) begin
            bus.i_AV_WaitRequest = 1'b1;
            waitLeft--;
         end else begin
            bus.i_AV_WaitRequest = 1'b0;
            waitLeft = perBeatWait;
            bus.i_AV_ReadData = rdBase + 32'(rdIdx);
            rdIdx++;
         end
      end else bus.i_AV_WaitRequest = 1'b0;
   end

   // transaction-level model and observation counters
   bit monOn = 0;
   bit busy = 0, mWrite = 0, doneNext = 0, rdPendV = 0, prevWW = 0;
   bit nDone, nPendV, expReady, expW, expR, beat, expWrReady;
   int mCnt = 0, pushed = 0, beatsDone = 0;
   logic [29:0] mAddr = '0;
   logic [3:0] mBe = '0;
   logic [31:0] rdPendD = '0, prevWD = '0;
   logic [31:0] holdQ[$];
   logic [31:0] wrBeats[$];
   logic [31:0] rdOut[$];
   int doneCnt = 0, busCycles = 0, readCycles = 0, waitCycles = 0, writeLow = 0;
   logic [29:0] lastRdAddr = '0, lastWrAddr = '0;

   always @(negedge r_Clk) if (monOn) begin
      expReady   = !busy;
      expW       = busy && mWrite && pushed > beatsDone;
      expR       = busy && !mWrite;
      beat       = (expW || expR) && !bus.i_AV_WaitRequest;
      expWrReady = busy && mWrite && pushed < mCnt && (pushed == beatsDone || beat);
      chk("cmd_ready", bus.o_Cmd_Ready, expReady);
      chk("av_write", bus.o_AV_Write, expW);
      chk("av_read", bus.o_AV_Read, expR);
      chk("av_addr", bus.o_AV_Addr, busy ? mAddr : 30'd0);
      chk("av_byteen", bus.o_AV_ByteEn, busy ? mBe : 4'd0);
      chk("av_burst", bus.o_AV_BurstCount, busy ? 64'(mCnt) : 64'd0);
      chk("wr_ready", bus.o_WrData_Ready, expWrReady);
      if (expW) chk("wr_data", bus.o_AV_WriteData, holdQ[0]);
      if (prevWW) begin
         chk("wait_hold_write", bus.o_AV_Write, 1'b1);
         chk("wait_hold_data", bus.o_AV_WriteData, prevWD);
      end
      chk("rd_valid", bus.o_RdData_Valid, rdPendV);
      if (rdPendV) chk("rd_data", bus.o_RdData, rdPendD);
      chk("done", bus.o_Done, doneNext);
      if (bus.o_Done) doneCnt++;
      if (bus.o_RdData_Valid) rdOut.push_back(bus.o_RdData);
      if (bus.o_AV_Read || bus.o_AV_Write) busCycles++;
      if (bus.o_AV_Read) begin
         readCycles++;
         lastRdAddr = bus.o_AV_Addr;
      end
      if (bus.o_AV_Write) lastWrAddr = bus.o_AV_Addr;
      if (bus.o_AV_Write && bus.i_AV_WaitRequest) waitCycles++;
      if (busy && mWrite && !bus.o_AV_Write) writeLow++;
      if (bus.o_AV_Write && !bus.i_AV_WaitRequest) wrBeats.push_back(bus.o_AV_WriteData);
      nDone = 0;
      nPendV = 0;
      prevWW = expW && bus.i_AV_WaitRequest;
      prevWD = bus.o_AV_WriteData;
      if (beat) begin
         beatsDone++;
         if (expW) void'(holdQ.pop_front());
         if (expR) begin
            nPendV = 1;
            rdPendD = bus.i_AV_ReadData;
         end
         if (beatsDone == mCnt) begin
            busy = 0;
            nDone = 1;
         end
      end
      if (expWrReady && bus.i_WrData_Valid) begin
         holdQ.push_back(bus.i_WrData);
         pushed++;
      end
      if (expReady && bus.i_Cmd_Valid) begin
         if (bus.i_Cmd_BurstCount == 0) nDone = 1;
         else begin
            busy = 1;
            mWrite = bus.i_Cmd_Write;
            mAddr = bus.i_Cmd_Addr;
            mBe = bus.i_Cmd_ByteEn;
            mCnt = int'(bus.i_Cmd_BurstCount);
            pushed = 0;
            beatsDone = 0;
            holdQ.delete();
         end
      end
      if (r_Reset) begin
         busy = 0;
         nDone = 0;
         nPendV = 0;
         prevWW = 0;
         holdQ.delete();
      end
      doneNext = nDone;
      rdPendV = nPendV;
   end

   logic [31:0] wq[4];

   task automatic sendCmd(input logic w, input logic [29:0] a, input logic [3:0] be, input logic [7:0] n);
      bit ok = 0;
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Cmd_Write = w;
      bus.i_Cmd_Addr = a;
      bus.i_Cmd_ByteEn = be;
      bus.i_Cmd_BurstCount = n;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge r_Clk);
         ok = bus.o_Cmd_Ready;
         @(posedge r_Clk);
         #1;
      end
      bus.i_Cmd_Valid = 1'b0;
      if (!ok) chk("cmd_accept_timeout", 0, 1);
   endtask

   task automatic writeStream(input int n, input int gapAfter, input int gapLen);
      int idx = 0;
      int gapCnt = 0;
      bit inGap;
      for (int c = 0; c < 200 && idx < n; c++) begin
         inGap = idx == gapAfter && gapCnt < gapLen;
         if (inGap) gapCnt++;
         bus.i_WrData_Valid = !inGap;
         bus.i_WrData = wq[idx];
         @(negedge r_Clk);
         if (bus.i_WrData_Valid && bus.o_WrData_Ready) idx++;
         @(posedge r_Clk);
         #1;
      end
      bus.i_WrData_Valid = 1'b0;
      if (idx < n) chk("wrdata_stream_timeout", 64'(idx), 64'(n));
   endtask

   task automatic waitDone(input int budget, input string nm);
      bit seen = 0;
      for (int t = 0; t < budget && !seen; t++) begin
         @(negedge r_Clk);
         seen = bus.o_Done;
      end
      chk(nm, seen, 1'b1);
      repeat (2) @(posedge r_Clk);
      #1;
   endtask

   task automatic resetChk(input string nm);
      chk({nm, "_ready"}, bus.o_Cmd_Ready, 1'b1);
      chk({nm, "_read"}, bus.o_AV_Read, 1'b0);
      chk({nm, "_write"}, bus.o_AV_Write, 1'b0);
      chk({nm, "_done"}, bus.o_Done, 1'b0);
      chk({nm, "_rdvalid"}, bus.o_RdData_Valid, 1'b0);
      chk({nm, "_rddata"}, bus.o_RdData, 32'd0);
      chk({nm, "_addr"}, bus.o_AV_Addr, 30'd0);
      chk({nm, "_burst"}, bus.o_AV_BurstCount, 8'd0);
      chk({nm, "_wrready"}, bus.o_WrData_Ready, 1'b0);
   endtask

   initial begin
      int s, d0, r0, b0, n;
      bus.i_Cmd_Valid = 0;
      bus.i_Cmd_Write = 0;
      bus.i_Cmd_Addr = '0;
      bus.i_Cmd_ByteEn = '0;
      bus.i_Cmd_BurstCount = '0;
      bus.i_WrData = '0;
      bus.i_WrData_Valid = 0;
      bus.i_AV_ReadData = '0;
      bus.i_AV_WaitRequest = 0;
      repeat (3) @(posedge r_Clk);
      #1;
      r_Reset = 0;
      monOn = 1;
      @(negedge r_Clk);
      resetChk("reset");
      @(posedge r_Clk);
      #1;

      // continuous 4-beat write, one wait cycle per beat
      perBeatWait = 1;
      waitLeft = 1;
      s = wrBeats.size();
      d0 = doneCnt;
      b0 = writeLow;
      wq = '{32'd1, 32'd2, 32'd3, 32'd4};
      sendCmd(1'b1, 30'd0, 4'hF, 8'd4);
      writeStream(4, 99, 0);
      waitDone(30, "wr4_done_timeout");
      chk("wr4_beats", 64'(wrBeats.size() - s), 4);
      for (int k = 0; k < 4; k++) chk("wr4_data", wrBeats[s + k], 32'(k + 1));
      chk("wr4_done_count", 64'(doneCnt - d0), 1);
      chk("wr4_write_low", 64'(writeLow - b0), 1);

      // write with a 4-cycle data gap after beat 2
      perBeatWait = 0;
      waitLeft = 0;
      s = wrBeats.size();
      d0 = doneCnt;
      b0 = writeLow;
      wq = '{32'h11, 32'h22, 32'h33, 32'h44};
      sendCmd(1'b1, 30'h100, 4'hF, 8'd4);
      writeStream(4, 2, 4);
      waitDone(30, "gap_done_timeout");
      chk("gap_beats", 64'(wrBeats.size() - s), 4);
      for (int k = 0; k < 4; k++) chk("gap_data", wrBeats[s + k], 32'h11 * 32'(k + 1));
      chk("gap_write_low", 64'(writeLow - b0), 5);
      chk("gap_addr", lastWrAddr, 30'h100);
      chk("gap_done_count", 64'(doneCnt - d0), 1);

      // 4-beat read, three initial wait cycles
      perBeatWait = 0;
      waitLeft = 3;
      rdBase = 32'hA0;
      rdIdx = 0;
      r0 = rdOut.size();
      b0 = readCycles;
      d0 = doneCnt;
      sendCmd(1'b0, 30'd0, 4'hF, 8'd4);
      waitDone(30, "rd4_done_timeout");
      chk("rd4_count", 64'(rdOut.size() - r0), 4);
      for (int k = 0; k < 4; k++) chk("rd4_data", rdOut[r0 + k], 32'hA0 + 32'(k));
      chk("rd4_read_cycles", 64'(readCycles - b0), 7);
      chk("rd4_done_count", 64'(doneCnt - d0), 1);

      // zero-length command, then a read issued in its done cycle
      waitLeft = 0;
      rdBase = 32'hB0;
      rdIdx = 0;
      b0 = busCycles;
      r0 = readCycles;
      sendCmd(1'b1, 30'h123, 4'hF, 8'd0);
      bus.i_Cmd_Valid = 1'b1;
      bus.i_Cmd_Write = 1'b0;
      bus.i_Cmd_Addr = 30'h4000000;
      bus.i_Cmd_ByteEn = 4'h5;
      bus.i_Cmd_BurstCount = 8'd1;
      @(negedge r_Clk);
      chk("zl_done", bus.o_Done, 1'b1);
      chk("zl_ready", bus.o_Cmd_Ready, 1'b1);
      chk("zl_no_bus", 64'(busCycles - b0), 0);
      @(posedge r_Clk);
      #1;
      bus.i_Cmd_Valid = 1'b0;
      waitDone(20, "b2b_done_timeout");
      chk("b2b_read_cycles", 64'(readCycles - r0), 1);
      chk("b2b_addr", lastRdAddr, 30'h4000000);
      chk("b2b_rddata", rdOut[rdOut.size() - 1], 32'hB0);

      // reset after beat 2 of a 4-beat read
      perBeatWait = 0;
      waitLeft = 0;
      rdBase = 32'hC0;
      rdIdx = 0;
      r0 = rdOut.size();
      d0 = doneCnt;
      n = 0;
      sendCmd(1'b0, 30'h40, 4'hF, 8'd4);
      for (int t = 0; t < 30 && n < 2; t++) begin
         @(negedge r_Clk);
         if (bus.o_AV_Read && !bus.i_AV_WaitRequest) n++;
      end
      chk("rst_two_beats", 64'(n), 2);
      @(posedge r_Clk);
      #1;
      r_Reset = 1'b1;
      @(posedge r_Clk);
      #1;
      r_Reset = 1'b0;
      @(negedge r_Clk);
      resetChk("abort");
      repeat (5) @(negedge r_Clk);
      chk("abort_no_done", 64'(doneCnt - d0), 0);
      chk("abort_rd_count", 64'(rdOut.size() - r0), 2);
      chk("abort_rd_first", rdOut[r0], 32'hC0);
      chk("abort_rd_second", rdOut[r0 + 1], 32'hC1);
      @(posedge r_Clk);
      #1;

      // single-beat write held off by 10 wait cycles
      perBeatWait = 0;
      waitLeft = 10;
      s = wrBeats.size();
      d0 = doneCnt;
      b0 = waitCycles;
      wq = '{32'h5A5A5A5A, 32'd0, 32'd0, 32'd0};
      sendCmd(1'b1, 30'h55, 4'h3, 8'd1);
      writeStream(1, 99, 0);
      waitDone(30, "wait_done_timeout");
      chk("wait_cycles", 64'(waitCycles - b0), 10);
      chk("wait_beats", 64'(wrBeats.size() - s), 1);
      chk("wait_data", wrBeats[s], 32'h5A5A5A5A);
      chk("wait_done_count", 64'(doneCnt - d0), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
